// File: rtl/cache_axi_bridge_if.sv
// AXI4 master-side channel bundle between the cache line bridge and the interconnect.
// master = bridge side, slave = interconnect side.
interface cache_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cache_axi_bridge.sv
// Cache line transfer bridge: one 8-word line per request, issued as a single
// 8-beat INCR burst on AXI4, completed with a one-cycle axi_gnt pulse.
module cache_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         axi_addr,
  input  logic                axi_rd_req,
  input  logic                axi_wr_req,
  input  logic [31:0]         axi_wr_data [0:7],
  output logic                axi_gnt,
  output logic [31:0]         axi_rd_data [0:7],
  cache_axi_bridge_if.master  axi
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] AR   = 3'd1;
  localparam logic [2:0] R    = 3'd2;
  localparam logic [2:0] AW   = 3'd3;
  localparam logic [2:0] W    = 3'd4;
  localparam logic [2:0] B    = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  logic [2:0]  state_reg;
  logic [2:0]  cnt_reg;
  logic [31:0] addr_reg;
  logic [31:0] wbuf_reg [0:7];
  logic [31:0] rbuf_reg [0:7];

  logic accept_wr;
  logic accept_rd;
  logic rd_beat;
  logic wr_beat;

  // Write wins when both requests are present.
  assign accept_wr = (state_reg == IDLE) && axi_wr_req;
  assign accept_rd = (state_reg == IDLE) && !axi_wr_req && axi_rd_req;
  assign rd_beat   = (state_reg == R) && axi.rvalid;
  assign wr_beat   = (state_reg == W) && axi.wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      addr_reg  <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept_wr) begin
            addr_reg  <= {axi_addr[31:5], 5'b0};
            state_reg <= AW;
          end else if (accept_rd) begin
            addr_reg  <= {axi_addr[31:5], 5'b0};
            state_reg <= AR;
          end
        end
        AR: if (axi.arready) state_reg <= R;
        R: begin
          if (rd_beat) begin
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) state_reg <= DONE;
          end
        end
        AW: if (axi.awready) state_reg <= W;
        W: begin
          if (wr_beat) begin
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) state_reg <= B;
          end
        end
        B: if (axi.bvalid) state_reg <= DONE;
        DONE: begin
          cnt_reg   <= 3'd0;
          state_reg <= IDLE;
        end
        default: begin
          cnt_reg   <= 3'd0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Per-word line buffers; the read buffer only changes on its own beat.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wbuf_reg[gi] <= 32'd0;
        end else if (accept_wr) begin
          wbuf_reg[gi] <= axi_wr_data[gi];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rbuf_reg[gi] <= 32'd0;
        end else if (rd_beat && (cnt_reg == 3'(gi))) begin
          rbuf_reg[gi] <= axi.rdata;
        end
      end

      assign axi_rd_data[gi] = rbuf_reg[gi];
    end
  endgenerate

  assign axi_gnt = (state_reg == DONE);

  assign axi.arid    = AXI_ID;
  assign axi.arlen   = 8'd7;
  assign axi.arsize  = 3'd2;
  assign axi.arburst = 2'b01;
  assign axi.araddr  = addr_reg;
  assign axi.arvalid = (state_reg == AR);
  assign axi.rready  = (state_reg == R);

  assign axi.awid    = AXI_ID;
  assign axi.awlen   = 8'd7;
  assign axi.awsize  = 3'd2;
  assign axi.awburst = 2'b01;
  assign axi.awaddr  = addr_reg;
  assign axi.awvalid = (state_reg == AW);

  assign axi.wdata   = wbuf_reg[cnt_reg];
  assign axi.wstrb   = 4'hF;
  assign axi.wvalid  = (state_reg == W);
  assign axi.wlast   = (state_reg == W) && (cnt_reg == 3'd7);
  assign axi.bready  = (state_reg == B);

  // Response codes and rlast do not affect completion; beat counting does.
  logic unused_inputs;
  assign unused_inputs = ^{axi_addr[4:0], axi.rresp, axi.rlast, axi.bresp};

endmodule

// File: doc/cache_axi_bridge.md
# cache_axi_bridge

Line-transfer responder that sits between the data cache's refill/write-back port and the AXI4 interconnect. It accepts one 8-word line request at a time from the cache (`axi_rd_req` / `axi_wr_req` with `axi_addr`). It executes the request as a single 8-beat INCR burst on the AXI4 master channels, then pulses `axi_gnt` for one cycle. Read lines are buffered and held stable for the cache's refill-write cycle.

## Interface
- `AXI_ID`, default 4'd1: constant ID driven on `arid`/`awid`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `axi_addr`  in  32  line address from cache; bits [4:0] ignored (forced 0 on AXI).
- `axi_rd_req`  in  1  line-read request; held high by cache until `axi_gnt`.
- `axi_wr_req`  in  1  line-write-back request; held high by cache until `axi_gnt`.
- `axi_wr_data[0:7]`  in  32 each  write-back line, word 0 at lowest address.
- `axi_gnt`  out  1  one-cycle completion pulse.
- `axi_rd_data[0:7]`  out  32 each  read line buffer, word 0 at lowest address.
- `arid`/`awid` out 4, `arlen`/`awlen` out 8, `arsize`/`awsize` out 3, `arburst`/`awburst` out 2: constants `AXI_ID`, 8'd7, 3'd2, 2'b01.
- `araddr`, `arvalid`, `arready`: out 32, out 1, in 1; AR channel.
- `rdata`, `rresp`, `rlast`, `rvalid`, `rready`: in 32, in 2, in 1, in 1, out 1; R channel.
- `awaddr`, `awvalid`, `awready`: out 32, out 1, in 1; AW channel.
- `wdata`, `wstrb`, `wlast`, `wvalid`, `wready`: out 32, out 4, out 1, out 1, in 1; W channel.
- `bresp`, `bvalid`, `bready`: in 2, in 1, out 1; B channel.

## Operation
- States: IDLE, AR, R, AW, W, B, DONE. Registered state; all AXI valid/ready outputs are decoded from state.
- IDLE:
  - `axi_wr_req` high: latch `{axi_addr[31:5],5'b0}` and all 8 `axi_wr_data` words, go to AW.
  - Else `axi_rd_req` high: latch the address, go to AR.
  - Write has priority when both requests are high.
- AR: `arvalid`=1, `araddr` = latched address. On `arready` go to R.
- R:
  - `rready`=1. Each `rvalid` beat stores `rdata` into `axi_rd_data[beat]` and increments a 3-bit beat counter.
  - On the 8th beat (counter==7) go to DONE.
  - Completion is counter-based. `rlast`, `rid` and `rresp` are not checked; error responses still complete normally.
- AW: `awvalid`=1, `awaddr` = latched address. On `awready` go to W.
- W:
  - `wvalid`=1, `wdata` = latched word[counter], `wstrb`=4'hF, `wlast`=(counter==7).
  - Each `wready` increments the counter. The beat with counter==7 goes to B.
- B: `bready`=1. On `bvalid` go to DONE. `bresp` is ignored.
- DONE: `axi_gnt`=1 for exactly one cycle, counter cleared, then IDLE.
  - Requests are not sampled in DONE, because the cache still holds its request during the `axi_gnt` cycle.
- `axi_rd_data` holds the last read line until beat 0 of the next read burst. Write bursts never modify it.
- Reset (asynchronous, any state):
  - State returns to IDLE and the counter is cleared.
  - All valid/ready outputs go to 0 and `axi_gnt` goes to 0.
  - The read buffer, latched address and latched data are cleared to 0.
  - An in-flight burst is abandoned. The interconnect must be reset together with this block.

## Timing
- Reset values: `axi_gnt`, `arvalid`, `rready`, `awvalid`, `wvalid`, `wlast`, `bready` = 0.
- Reset values: `araddr`, `awaddr`, `wdata`, all `axi_rd_data` = 0.
- Constant outputs hold their constant values during reset.
- Read, zero-wait slave (request seen in IDLE at cycle 0):
  - Cycle 1: `arvalid`.
  - Cycles 2–9: R beats.
  - Cycle 10: `axi_gnt`.
  - `axi_rd_data` is valid from cycle 10 and remains so at cycle 11, the cache's refill write.
- Write, zero-wait slave (request at cycle 0):
  - Cycle 1: `awvalid`.
  - Cycles 2–9: W beats.
  - Cycle 10: `bready` meets `bvalid`.
  - Cycle 11: `axi_gnt`.
- Back-to-back requests: the earliest new request is accepted in the cycle after `axi_gnt`. For the cache's write-back followed by refill, the minimum total is 23 cycles.
- Valid outputs stay asserted with stable address/data until the handshake completes. Valid never depends combinationally on ready.
- Stalls (`rvalid`=0 or `wready`=0) freeze the counter. Beat order stays strictly 0..7.

## Test plan
- Read, zero-wait:
  - Stimulus: `axi_rd_req`, `axi_addr`=0x1FC0_0A37; slave returns 0x100..0x107.
  - Required: `araddr`=0x1FC0_0A20, `arlen`=7; `axi_gnt` pulse at cycle 10; `axi_rd_data[k]`=0x100+k, stable at cycle 11.
- Write with stalls:
  - Stimulus: `axi_wr_req`, words 0xA0..0xA7; `wready` toggling 1,0,1,0...; `bvalid` 3 cycles after `wlast`.
  - Required: `wdata` sequence 0xA0..0xA7 with no repeats or skips; `wlast` only on 0xA7; single `axi_gnt` after B.
- Write-back then refill:
  - Stimulus: `axi_wr_req` deasserted and `axi_rd_req` asserted in the cycle after `axi_gnt`.
  - Required: exactly one AW burst, then one AR burst; no second AW; `axi_rd_data` unchanged by the write.
- Simultaneous requests: `axi_wr_req` and `axi_rd_req` both high -> AW issued first; AR only after a new acceptance from IDLE.
- Error/rlast tolerance: `rresp`=2'b10 on all beats and `rlast` missing -> burst still completes after 8 beats with data captured and `axi_gnt` pulsed.
- Reset mid-burst:
  - Stimulus: assert `rst` during R beat 4 (asynchronously, between edges).
  - Required: `rready`=0 and `axi_gnt`=0 immediately, `axi_rd_data` all 0. After release, a new read completes correctly from beat 0.
